// File: rtl/change_dispenser.sv
// Coin change dispenser: latches the machine balance when the return request has been
// held for exactly kTriggerHold cycles, then pays it out greedily one coin per handshake.
module change_dispenser #(
    parameter int kTotalBits   = 31,
    parameter int kCoinValue0  = 100,
    parameter int kCoinValue1  = 500,
    parameter int kCoinValue2  = 1000,
    parameter int kTriggerHold = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [kTotalBits-1:0] i_return_trigger_point,
    input  logic [kTotalBits-1:0] i_current_total,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [2:0]            o_return_coin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_residue
);

    localparam logic [kTotalBits-1:0] kCoin0 = kTotalBits'(kCoinValue0);
    localparam logic [kTotalBits-1:0] kCoin1 = kTotalBits'(kCoinValue1);
    localparam logic [kTotalBits-1:0] kCoin2 = kTotalBits'(kCoinValue2);
    localparam logic [kTotalBits-1:0] kHold  = kTotalBits'(kTriggerHold);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    // Initialisers give the reset values from time 0, before any clock edge.
    state_t                  state   = IDLE;
    state_t                  state_next;
    logic [kTotalBits-1:0]   balance = '0;
    logic [kTotalBits-1:0]   balance_next;
    logic [kTotalBits-1:0]   residue = '0;
    logic [kTotalBits-1:0]   residue_next;
    logic [2:0]              coin_sel;
    logic [kTotalBits-1:0]   coin_amt;

    // Largest coin not exceeding the balance; zero select means nothing can be paid.
    always_comb begin
        coin_sel = '0;
        coin_amt = '0;
        if (balance >= kCoin2) begin
            coin_sel = 3'b100;
            coin_amt = kCoin2;
        end else if (balance >= kCoin1) begin
            coin_sel = 3'b010;
            coin_amt = kCoin1;
        end else if (balance >= kCoin0) begin
            coin_sel = 3'b001;
            coin_amt = kCoin0;
        end
    end

    always_comb begin
        state_next    = state;
        balance_next  = balance;
        residue_next  = residue;
        o_coin_valid  = 1'b0;
        o_return_coin = '0;
        o_busy        = (state != IDLE);
        o_done        = 1'b0;
        case (state)
            IDLE: begin
                if (i_return_trigger_point == kHold && i_current_total != '0) begin
                    balance_next = i_current_total;
                    state_next   = DISPENSE;
                end
            end
            DISPENSE: begin
                if (coin_sel != '0) begin
                    o_coin_valid  = 1'b1;
                    o_return_coin = coin_sel;
                    if (i_coin_ready) begin
                        balance_next = balance - coin_amt;
                    end
                end else begin
                    residue_next = balance;
                    state_next   = DONE;
                end
            end
            DONE: begin
                o_done     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= IDLE;
            balance <= '0;
            residue <= '0;
        end else begin
            state   <= state_next;
            balance <= balance_next;
            residue <= residue_next;
        end
    end

    assign o_residue = residue;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: greedy-payout reference model checked every cycle,
// directed scenarios with literal coin lists, then randomized payouts with resets.
module tb_change_dispenser;

    localparam int W    = 31;
    localparam int C0   = 100;
    localparam int C1   = 500;
    localparam int C2   = 1000;
    localparam int HOLD = 2;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] trig    = '0;
    logic [W-1:0] total   = '0;
    logic         ready   = 1'b0;
    logic         o_coin_valid;
    logic [2:0]   o_return_coin;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_residue;

    change_dispenser #(
        .kTotalBits  (W),
        .kCoinValue0 (C0),
        .kCoinValue1 (C1),
        .kCoinValue2 (C2),
        .kTriggerHold(HOLD)
    ) dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .i_return_trigger_point(trig),
        .i_current_total       (total),
        .i_coin_ready          (ready),
        .o_coin_valid          (o_coin_valid),
        .o_return_coin         (o_return_coin),
        .o_busy                (o_busy),
        .o_done                (o_done),
        .o_residue             (o_residue)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the whole payout is planned as a coin list at the start.
    bit     m_active  = 1'b0;
    int     m_coins[$];
    int     m_tail    = 0;
    longint m_residue = 0;
    longint m_pend    = 0;
    longint m_r       = 0;

    int coin_log[$];
    int done_cnt = 0;

    function automatic int bits_to_val(input logic [2:0] b);
        case (b)
            3'b001:  return C0;
            3'b010:  return C1;
            3'b100:  return C2;
            default: return -1;
        endcase
    endfunction

    function automatic logic [2:0] val_to_bits(input int v);
        if (v == C2) return 3'b100;
        if (v == C1) return 3'b010;
        if (v == C0) return 3'b001;
        return 3'b000;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            m_active  = 1'b0;
            m_coins.delete();
            m_tail    = 0;
            m_residue = 0;
        end else if (!m_active) begin
            if (trig == W'(HOLD) && total != '0) begin
                m_r = longint'(total);
                m_coins.delete();
                repeat (int'(m_r / C2)) m_coins.push_back(C2);
                m_r = m_r % C2;
                repeat (int'(m_r / C1)) m_coins.push_back(C1);
                m_r = m_r % C1;
                repeat (int'(m_r / C0)) m_coins.push_back(C0);
                m_pend   = m_r % C0;
                m_active = 1'b1;
                m_tail   = 0;
            end
        end else if (m_coins.size() > 0) begin
            if (ready) void'(m_coins.pop_front());
        end else if (m_tail == 0) begin
            m_residue = m_pend;
            m_tail    = 1;
        end else begin
            m_active = 1'b0;
        end
    end

    initial forever begin
        bit         e_valid;
        logic [2:0] e_coin;
        bit         e_done;
        @(negedge clk);
        e_valid = m_active && (m_coins.size() > 0);
        e_coin  = e_valid ? val_to_bits(m_coins[0]) : 3'b000;
        e_done  = m_active && (m_coins.size() == 0) && (m_tail == 1);
        check("coin_valid", longint'(o_coin_valid), longint'(e_valid));
        check("return_coin", longint'(o_return_coin), longint'(e_coin));
        check("busy", longint'(o_busy), longint'(m_active));
        check("done", longint'(o_done), longint'(e_done));
        check("residue", longint'(o_residue), m_residue);
        if (o_coin_valid && ready && reset_n) coin_log.push_back(bits_to_val(o_return_coin));
        if (o_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (m_active && n < budget) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, longint'(m_active), 0);
        check({name, "_busy_end"}, longint'(o_busy), 0);
    endtask

    task automatic expect_log(input string name, input int exp[$]);
        check({name, "_ncoins"}, coin_log.size(), exp.size());
        for (int i = 0; i < exp.size() && i < coin_log.size(); i++)
            check({name, "_coin"}, coin_log[i], exp[i]);
    endtask

    task automatic start_case(input int t);
        coin_log.delete();
        done_cnt = 0;
        total    = W'(t);
    endtask

    initial begin
        int e[$];
        #1;
        check("t0_valid", longint'(o_coin_valid), 0);
        check("t0_coin", longint'(o_return_coin), 0);
        check("t0_busy", longint'(o_busy), 0);
        check("t0_done", longint'(o_done), 0);
        check("t0_residue", longint'(o_residue), 0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // 1600 with trigger counting 0..3
        start_case(1600);
        ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            trig = W'(t);
            tick();
        end
        trig = '0;
        wait_idle("p1600", 50);
        e = {1000, 500, 100};
        expect_log("p1600", e);
        check("p1600_done", done_cnt, 1);
        check("p1600_residue", longint'(o_residue), 0);

        // 1500 with chute stalled for three cycles on the first coin
        start_case(1500);
        ready = 1'b0;
        trig  = W'(1); tick();
        trig  = W'(2); tick();
        trig  = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", longint'(o_coin_valid), 1);
            check("stall_coin", longint'(o_return_coin), 4);
        end
        ready = 1'b1;
        wait_idle("p1500", 50);
        e = {1000, 500};
        expect_log("p1500", e);
        check("p1500_done", done_cnt, 1);

        // zero balance, then a trigger that never reaches the hold count
        start_case(0);
        for (int t = 0; t < 4; t++) begin
            trig = W'(t);
            tick();
        end
        trig = '0;
        repeat (3) tick();
        total = W'(700);
        trig = W'(1); tick();
        trig = '0;    repeat (4) tick();
        check("nostart_ncoins", coin_log.size(), 0);
        check("nostart_done", done_cnt, 0);
        check("nostart_busy", longint'(o_busy), 0);

        // 250 leaves a residue of 50
        start_case(250);
        trig = W'(1); tick();
        trig = W'(2); tick();
        trig = '0;
        wait_idle("p250", 50);
        e = {100, 100};
        expect_log("p250", e);
        check("p250_done", done_cnt, 1);
        check("p250_residue", longint'(o_residue), 50);

        // reset after the first coin of a 1600 payout
        start_case(1600);
        trig = W'(1); tick();
        trig = W'(2); tick();
        trig = '0;    tick();
        reset_n = 1'b0;
        tick();
        check("rst_valid", longint'(o_coin_valid), 0);
        check("rst_coin", longint'(o_return_coin), 0);
        check("rst_busy", longint'(o_busy), 0);
        check("rst_done", longint'(o_done), 0);
        check("rst_residue", longint'(o_residue), 0);
        reset_n = 1'b1;
        repeat (6) tick();
        e = {1000};
        expect_log("rst", e);
        check("rst_no_done", done_cnt, 0);

        // trigger held for ten cycles, total withdrawn mid-payout
        start_case(600);
        for (int t = 1; t <= 10; t++) begin
            trig = W'(t);
            if (t == 4) total = '0;
            tick();
        end
        trig = '0;
        wait_idle("p600", 50);
        e = {500, 100};
        expect_log("p600", e);
        check("p600_done", done_cnt, 1);
        check("p600_residue", longint'(o_residue), 0);

        // randomized payouts with random chute stalls and occasional resets
        for (int k = 0; k < 60; k++) begin
            int hold_max;
            int n;
            total    = W'($urandom_range(0, 3500));
            hold_max = int'($urandom_range(0, 4));
            for (int t = 0; t <= hold_max; t++) begin
                trig  = W'(t);
                ready = 1'(($urandom & 1));
                if (t > HOLD && $urandom_range(0, 1) == 1) total = W'($urandom_range(0, 3500));
                tick();
            end
            trig = '0;
            n = 0;
            while (m_active && n < 300) begin
                ready   = 1'(($urandom & 1));
                reset_n = ($urandom_range(0, 39) == 0) ? 1'b0 : 1'b1;
                tick();
                n++;
            end
            reset_n = 1'b1;
            check("rand_timeout", longint'(m_active), 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
